// File: rtl/mac_accum_if.sv
// Product-in / result-out handshake bundle for mac_accum.
// The master side is the upstream multiplier plus the result consumer.
interface mac_accum_if #(
    parameter int P_W   = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
);
    logic             p_valid;
    logic             p_ready;
    logic [P_W-1:0]   p_data;
    logic             p_last;
    logic             acc_valid;
    logic             acc_ready;
    logic [ACC_W-1:0] acc_sum;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_ovf;

    modport master (
        output p_valid, p_data, p_last, acc_ready,
        input  p_ready, acc_valid, acc_sum, acc_cnt, acc_ovf
    );

    modport slave (
        input  p_valid, p_data, p_last, acc_ready,
        output p_ready, acc_valid, acc_sum, acc_cnt, acc_ovf
    );
endinterface

// File: rtl/mac_accum.sv
// Unsigned product accumulator: sums a group of products ended by p_last,
// then holds sum/count/carry until the consumer takes it.
module mac_accum #(
    parameter int P_W   = 32,
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input logic        clk,
    input logic        rst,
    mac_accum_if.slave bus
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             xfer;
    logic [ACC_W:0]   sum_nxt;

    // Handshake flags come straight from state, forced low during reset.
    always_comb begin
        bus.p_ready   = (state == ACCUM) && !rst;
        bus.acc_valid = (state == HOLD) && !rst;
        xfer          = bus.p_valid && bus.p_ready;
        sum_nxt       = {1'b0, sum} + {{(ACC_W + 1 - P_W){1'b0}}, bus.p_data};
    end

    assign bus.acc_sum = sum;
    assign bus.acc_cnt = cnt;
    assign bus.acc_ovf = ovf;

    // Group accumulation and result hold/release.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACCUM;
            sum   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (xfer) begin
                        sum <= sum_nxt[ACC_W-1:0];
                        ovf <= ovf | sum_nxt[ACC_W];
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        if (bus.p_last) state <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.acc_ready) begin
                        state <= ACCUM;
                        sum   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_accum.sv
// Self-checking bench for mac_accum: directed scenarios plus a
// scoreboard that predicts each emitted result and the handshake flags.
module tb_mac_accum;
    localparam int P_W   = 32;
    localparam int ACC_W = 40;
    localparam int CNT_W = 16;

    typedef struct {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    mac_accum_if #(.P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mac_accum #(.P_W(P_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    res_t             exp_q[$];
    logic [ACC_W:0]   m_sum = '0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_ovf = 1'b0;

    // Scoreboard: checks flags every edge, predicts and compares results.
    always @(posedge clk) begin
        logic exp_rdy;
        logic exp_vld;
        res_t r;
        exp_rdy = !rst && (exp_q.size() == 0);
        exp_vld = !rst && (exp_q.size() != 0);
        n_checks++;
        if (bus.p_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL sb_p_ready t=%0t got %b want %b",
                     $time, bus.p_ready, exp_rdy);
        end
        n_checks++;
        if (bus.acc_valid !== exp_vld) begin
            n_fail++;
            $display("FAIL sb_acc_valid t=%0t got %b want %b",
                     $time, bus.acc_valid, exp_vld);
        end
        if (rst) begin
            m_sum = '0;
            m_cnt = '0;
            m_ovf = 1'b0;
            exp_q.delete();
        end else if (exp_vld) begin
            if (bus.acc_ready) begin
                r = exp_q.pop_front();
                n_checks++;
                if (bus.acc_sum !== r.sum || bus.acc_cnt !== r.cnt ||
                    bus.acc_ovf !== r.ovf) begin
                    n_fail++;
                    $display("FAIL sb_result got %h/%0d/%b want %h/%0d/%b",
                             bus.acc_sum, bus.acc_cnt, bus.acc_ovf,
                             r.sum, r.cnt, r.ovf);
                end
            end
        end else if (bus.p_valid) begin
            m_sum = {1'b0, m_sum[ACC_W-1:0]} + {9'd0, bus.p_data};
            if (m_sum[ACC_W]) m_ovf = 1'b1;
            if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
            if (bus.p_last) begin
                r.sum = m_sum[ACC_W-1:0];
                r.cnt = m_cnt;
                r.ovf = m_ovf;
                exp_q.push_back(r);
                m_sum = '0;
                m_cnt = '0;
                m_ovf = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [P_W-1:0] d,
                         input logic l);
        bus.p_valid = v;
        bus.p_data  = d;
        bus.p_last  = l;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h5, 1'b1);
        bus.acc_ready = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.p_ready !== 1'b0 || bus.acc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags got rdy=%b vld=%b want 0/0",
                     bus.p_ready, bus.acc_valid);
        end
        n_checks++;
        if (bus.acc_sum !== 40'h0 || bus.acc_cnt !== 16'd0 ||
            bus.acc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got %h/%0d/%b want 0/0/0",
                     bus.acc_sum, bus.acc_cnt, bus.acc_ovf);
        end
        drive(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.p_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release got p_ready=%b want 1", bus.p_ready);
        end
    endtask

    task automatic test_basic();
        bus.acc_ready = 1'b1;
        drive(1'b1, 32'h2, 1'b0);
        step();
        drive(1'b1, 32'h3, 1'b0);
        step();
        drive(1'b1, 32'h5, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.acc_valid !== 1'b1 || bus.acc_sum !== 40'hA ||
            bus.acc_cnt !== 16'd3 || bus.acc_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result got v=%b %h/%0d/%b want 1 a/3/0",
                     bus.acc_valid, bus.acc_sum, bus.acc_cnt, bus.acc_ovf);
        end
        step();
        n_checks++;
        if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_release got vld=%b rdy=%b want 0/1",
                     bus.acc_valid, bus.p_ready);
        end
    endtask

    task automatic test_backpressure();
        bus.acc_ready = 1'b0;
        drive(1'b1, 32'hFFFF_FFFF, 1'b1);
        step();
        drive(1'b1, 32'h1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (bus.acc_valid !== 1'b1 || bus.p_ready !== 1'b0 ||
                bus.acc_sum !== 40'h00FFFFFFFF || bus.acc_cnt !== 16'd1) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b r=%b %h/%0d",
                         i, bus.acc_valid, bus.p_ready,
                         bus.acc_sum, bus.acc_cnt);
            end
            step();
        end
        bus.acc_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        step();
        n_checks++;
        if (bus.acc_sum !== 40'h0 || bus.acc_cnt !== 16'd0 ||
            bus.p_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_clear got %h/%0d r=%b want 0/0 r=1",
                     bus.acc_sum, bus.acc_cnt, bus.p_ready);
        end
        drive(1'b1, 32'h1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.acc_sum !== 40'h1 || bus.acc_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL bp_next got %h/%0d want 1/1",
                     bus.acc_sum, bus.acc_cnt);
        end
        step();
    endtask

    task automatic test_overflow();
        bus.acc_ready = 1'b0;
        for (int i = 0; i < 257; i++) begin
            drive(1'b1, 32'hFFFF_FFFF, (i == 256));
            step();
        end
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.acc_sum !== 40'h00FFFFFEFF || bus.acc_cnt !== 16'd257 ||
            bus.acc_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_result got %h/%0d/%b want fffffeff/257/1",
                     bus.acc_sum, bus.acc_cnt, bus.acc_ovf);
        end
        bus.acc_ready = 1'b1;
        step();
        drive(1'b1, 32'h1, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.acc_ovf !== 1'b0 || bus.acc_sum !== 40'h1 ||
            bus.acc_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL ovf_clear got %h/%0d/%b want 1/1/0",
                     bus.acc_sum, bus.acc_cnt, bus.acc_ovf);
        end
        step();
    endtask

    task automatic test_reset_mid();
        bus.acc_ready = 1'b1;
        drive(1'b1, 32'h10, 1'b0);
        step();
        step();
        drive(1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.acc_sum !== 40'h0 || bus.acc_valid !== 1'b0 ||
            bus.p_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_abort got %h v=%b r=%b want 0 v=0 r=1",
                     bus.acc_sum, bus.acc_valid, bus.p_ready);
        end
        drive(1'b1, 32'h7, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.acc_sum !== 40'h7 || bus.acc_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL rmid_result got %h/%0d want 7/1",
                     bus.acc_sum, bus.acc_cnt);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int low = 0;
        bus.acc_ready = 1'b1;
        drive(1'b1, 32'h4, 1'b1);
        step();
        if (!bus.p_ready) low++;
        n_checks++;
        if (bus.acc_sum !== 40'h4 || bus.acc_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL b2b_first got %h/%0d want 4/1",
                     bus.acc_sum, bus.acc_cnt);
        end
        drive(1'b1, 32'h6, 1'b0);
        step();
        if (!bus.p_ready) low++;
        step();
        if (!bus.p_ready) low++;
        drive(1'b1, 32'h8, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.acc_sum !== 40'hE || bus.acc_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b_second got %h/%0d want e/2",
                     bus.acc_sum, bus.acc_cnt);
        end
        n_checks++;
        if (low !== 1) begin
            n_fail++;
            $display("FAIL b2b_gap got %0d low cycles want 1", low);
        end
        step();
    endtask

    task automatic test_reset_hold();
        bus.acc_ready = 1'b0;
        drive(1'b1, 32'h9, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b0);
        n_checks++;
        if (bus.acc_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rhold_pending got %b want 1", bus.acc_valid);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.acc_valid !== 1'b0 || bus.p_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rhold_drop got v=%b r=%b want 0/1",
                     bus.acc_valid, bus.p_ready);
        end
        bus.acc_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (bus.acc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rhold_quiet[%0d] got %b want 0",
                         i, bus.acc_valid);
            end
        end
    endtask

    initial begin
        drive(1'b0, 32'h0, 1'b0);
        bus.acc_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_reset_hold();
        step();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
